// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter:
// FSM states, grant-source encoding and read-latency bounds.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_e;

    typedef enum logic {
        GNT_INSTR = 1'b0,
        GNT_DATA  = 1'b1
    } gnt_src_e;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 4;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/mem_port_arbiter_arb_select.sv
// Fetch/data priority selection with one-transaction fairness.
// gnt_o is one-hot: bit 0 = fetch, bit 1 = data.
module arb_select
    import mem_port_arbiter_pkg::*;
(
    input  logic       if_req,
    input  logic       d_req,
    input  gnt_src_e   last_gnt,
    output logic [1:0] gnt_o
);

    logic if_first;

    // Fetch wins a tie only right after a data access.
    assign if_first = if_req && d_req && (last_gnt == GNT_DATA);

    always_comb begin
        gnt_o = 2'b00;
        unique case (1'b1)
            (if_req && (!d_req || if_first)): gnt_o = 2'b01;
            (d_req && !if_first):             gnt_o = 2'b10;
            default:                          gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port SRAM arbiter between instruction fetch and data accesses,
// one read outstanding, fixed read latency LAT.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic        mem_cs,
    output logic        mem_oe,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        pc_stall
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    gnt_src_e           last_q, last_d;
    logic [31:0]        addr_q, addr_d;

    logic [1:0] sel;
    logic       idle;
    logic       gnt_i;
    logic       gnt_d;
    logic       d_mis;
    logic       d_acc;

    arb_select u_arb_select (
        .if_req   (if_req),
        .d_req    (d_req),
        .last_gnt (last_q),
        .gnt_o    (sel)
    );

    // rst_n gates the combinational grants so every output is low in reset.
    assign idle   = (state_q == IDLE);
    assign gnt_i  = rst_n && idle && sel[0];
    assign gnt_d  = rst_n && idle && sel[1];
    assign d_mis  = (d_addr[1:0] != 2'b00);
    assign d_acc  = gnt_d && !d_mis;

    assign if_gnt   = gnt_i;
    assign d_gnt    = gnt_d;
    assign d_err    = gnt_d && d_mis;
    assign pc_stall = rst_n && if_req && !gnt_i;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        addr_d    = addr_q;
        mem_cs    = 1'b0;
        mem_oe    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        if_rvalid = 1'b0;
        if_rdata  = 32'h0;
        d_rvalid  = 1'b0;
        d_rdata   = 32'h0;
        unique case (state_q)
            IDLE: begin
                if (gnt_i) begin
                    mem_cs   = 1'b1;
                    mem_oe   = 1'b1;
                    mem_addr = if_addr & WORD_MASK;
                    addr_d   = if_addr & WORD_MASK;
                    last_d   = GNT_INSTR;
                    cnt_d    = CNT_W'(LAT);
                    state_d  = BUSY_I;
                end else if (d_acc) begin
                    mem_cs   = 1'b1;
                    mem_addr = d_addr & WORD_MASK;
                    last_d   = GNT_DATA;
                    if (d_we) begin
                        mem_we    = 1'b1;
                        mem_wdata = d_wdata;
                    end else begin
                        mem_oe  = 1'b1;
                        addr_d  = d_addr & WORD_MASK;
                        cnt_d   = CNT_W'(LAT);
                        state_d = BUSY_D;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                mem_cs   = 1'b1;
                mem_oe   = 1'b1;
                mem_addr = addr_q;
                if (cnt_q == CNT_W'(1)) begin
                    if (state_q == BUSY_I) begin
                        if_rvalid = 1'b1;
                        if_rdata  = mem_rdata;
                    end else begin
                        d_rvalid = 1'b1;
                        d_rdata  = mem_rdata;
                    end
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= GNT_INSTR;
            addr_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus pushes
// expected read responses, a negedge monitor pops and compares them.
module tb_mem_port_arbiter;

    localparam int          LAT = 2;
    localparam int          P   = LAT + 1;
    localparam logic [31:0] KEY = 32'h5A5A_F00F;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic        d_err;
    logic [31:0] d_rdata;
    logic        mem_cs;
    logic        mem_oe;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        pc_stall;

    mem_port_arbiter #(.LAT(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_err     (d_err),
        .d_rdata   (d_rdata),
        .mem_cs    (mem_cs),
        .mem_oe    (mem_oe),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .pc_stall  (pc_stall)
    );

    // SRAM stand-in: data is a keyed function of the address; junk when idle.
    assign mem_rdata = mem_oe ? (mem_addr ^ KEY) : 32'hFFFF_FFFF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp;
    int   n_fail;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mdl(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ KEY;
    endfunction

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    exp_t e;
    always @(negedge clk) begin
        if (!if_rvalid) chk("if_rdata_zero", if_rdata, 32'h0);
        if (!d_rvalid) chk("d_rdata_zero", d_rdata, 32'h0);
        if (if_rvalid || d_rvalid) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_rvalid: got if=%b d=%b want none",
                         if_rvalid, d_rvalid);
            end else begin
                e = sbq.pop_front();
                chk("rvalid_port", {31'b0, d_rvalid}, {31'b0, e.port});
                chk("rvalid_one", {31'b0, if_rvalid & d_rvalid}, 32'h0);
                chk("rdata", d_rvalid ? d_rdata : if_rdata, e.data);
            end
        end
    end

    int run_i;
    int run_d;
    int max_run;
    logic ed;
    logic ei;

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        if_req  = 1'b1;
        if_addr = 32'h0040_0020;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h1000_0004;
        d_wdata = 32'h0;

        // Reset with both requests up: everything quiet.
        nxt();
        smp();
        chk("rst_if_gnt", if_gnt, 0);
        chk("rst_d_gnt", d_gnt, 0);
        chk("rst_mem_cs", mem_cs, 0);
        chk("rst_pc_stall", pc_stall, 0);
        chk("rst_d_err", d_err, 0);
        nxt();

        // Lone fetch, granted in the release cycle; low addr bits ignored.
        rst_n   = 1'b1;
        d_req   = 1'b0;
        if_addr = 32'h0040_0022;
        smp();
        chk("t1_if_gnt", if_gnt, 1);
        chk("t1_mem_cs", mem_cs, 1);
        chk("t1_mem_oe", mem_oe, 1);
        chk("t1_mem_addr", mem_addr, 32'h0040_0020);
        chk("t1_pc_stall", pc_stall, 0);
        sbq.push_back('{1'b0, mdl(32'h0040_0020)});
        nxt();
        if_req = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            smp();
            chk("t1_rvalid_time", if_rvalid, (k == LAT));
            chk("t1_busy_cs", mem_cs, 1);
            chk("t1_busy_addr", mem_addr, 32'h0040_0020);
            chk("t1_busy_nognt", if_gnt, 0);
            nxt();
        end
        smp();
        chk("t1_back_idle", mem_cs, 0);
        nxt();

        // Simultaneous fetch and data read: data first after a fetch.
        if_req  = 1'b1;
        if_addr = 32'h0040_0024;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h1000_0004;
        smp();
        chk("t2_d_gnt", d_gnt, 1);
        chk("t2_if_gnt", if_gnt, 0);
        chk("t2_pc_stall", pc_stall, 1);
        chk("t2_mem_addr", mem_addr, 32'h1000_0004);
        sbq.push_back('{1'b1, mdl(32'h1000_0004)});
        nxt();
        d_req = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            smp();
            chk("t2_stall_busy", pc_stall, 1);
            chk("t2_no_if_gnt", if_gnt, 0);
            chk("t2_d_rvalid_time", d_rvalid, (k == LAT));
            nxt();
        end
        smp();
        chk("t2_if_gnt_late", if_gnt, 1);
        chk("t2_stall_done", pc_stall, 0);
        chk("t2_if_addr", mem_addr, 32'h0040_0024);
        sbq.push_back('{1'b0, mdl(32'h0040_0024)});
        nxt();
        if_req = 1'b0;
        for (int k = 0; k < LAT; k++) nxt();

        // Data write with fetch pending, then fetch wins on fairness.
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h1000_0008;
        d_wdata = 32'hDEAD_BEEF;
        if_req  = 1'b1;
        if_addr = 32'h0040_0028;
        smp();
        chk("t3_d_gnt", d_gnt, 1);
        chk("t3_mem_we", mem_we, 1);
        chk("t3_mem_oe", mem_oe, 0);
        chk("t3_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("t3_waddr", mem_addr, 32'h1000_0008);
        chk("t3_if_wait", if_gnt, 0);
        nxt();
        smp();
        chk("t3_fair_if_gnt", if_gnt, 1);
        chk("t3_no_d_gnt", d_gnt, 0);
        chk("t3_we_once", mem_we, 0);
        chk("t3_if_addr", mem_addr, 32'h0040_0028);
        sbq.push_back('{1'b0, mdl(32'h0040_0028)});
        nxt();
        if_req = 1'b0;
        d_req  = 1'b0;
        d_we   = 1'b0;
        for (int k = 0; k < LAT; k++) nxt();

        // Misaligned data request: error grant, no memory access.
        d_req  = 1'b1;
        d_addr = 32'h1000_0002;
        smp();
        chk("t4_d_err", d_err, 1);
        chk("t4_d_gnt", d_gnt, 1);
        chk("t4_mem_cs", mem_cs, 0);
        chk("t4_mem_oe", mem_oe, 0);
        nxt();
        d_req = 1'b0;
        smp();
        chk("t4_err_once", d_err, 0);
        chk("t4_idle", mem_cs, 0);
        nxt();

        // Continuous contention: D,I,D,I every LAT+1 cycles.
        if_req  = 1'b1;
        if_addr = 32'h0040_0030;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h1000_0010;
        run_i   = 0;
        run_d   = 0;
        max_run = 0;
        for (int k = 0; k < 20; k++) begin
            smp();
            ed = (k % P == 0) && ((k / P) % 2 == 0);
            ei = (k % P == 0) && ((k / P) % 2 == 1);
            chk("t6_d_gnt", d_gnt, ed);
            chk("t6_if_gnt", if_gnt, ei);
            if (ed) sbq.push_back('{1'b1, mdl(32'h1000_0010)});
            if (ei) sbq.push_back('{1'b0, mdl(32'h0040_0030)});
            run_i = pc_stall ? run_i + 1 : 0;
            run_d = (d_req && !d_gnt) ? run_d + 1 : 0;
            if (run_i > max_run) max_run = run_i;
            if (run_d > max_run) max_run = run_d;
            nxt();
        end
        chk("t6_max_wait_le6", (max_run <= 6), 1);
        if_req = 1'b0;
        d_req  = 1'b0;
        for (int k = 0; k < P; k++) nxt();

        // Reset during a fetch read abandons it.
        if_req  = 1'b1;
        if_addr = 32'h0040_0040;
        smp();
        chk("t7_if_gnt", if_gnt, 1);
        nxt();
        rst_n = 1'b0;
        #1;
        chk("t7_rst_cs", mem_cs, 0);
        chk("t7_rst_oe", mem_oe, 0);
        chk("t7_rst_addr", mem_addr, 32'h0);
        chk("t7_rst_rvalid", if_rvalid, 0);
        chk("t7_rst_stall", pc_stall, 0);
        chk("t7_rst_gnt", if_gnt, 0);
        nxt();
        nxt();
        rst_n   = 1'b1;
        if_addr = 32'h0040_0044;
        smp();
        chk("t7_first_gnt", if_gnt, 1);
        chk("t7_no_old_rvalid", if_rvalid, 0);
        chk("t7_new_addr", mem_addr, 32'h0040_0044);
        sbq.push_back('{1'b0, mdl(32'h0040_0044)});
        nxt();
        if_req = 1'b0;
        for (int k = 0; k < P; k++) nxt();

        smp();
        chk("sb_drained", sbq.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
